// File: rtl/queue_pkg.sv
// Shared FSM encoding, default parameters and the wait-estimate helper for the queue counter.
package queue_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INC    = 2'd1,
    DEC    = 2'd2,
    REJECT = 2'd3
  } state_t;

  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_MAX_COUNT  = 15;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_SVC_MIN    = 3;
  localparam int DEF_WAIT_W     = 8;

  // Product evaluated in 64 bits so the clamp works for any practical width.
  function automatic longint unsigned sat_wait(input longint unsigned cnt,
                                               input longint unsigned svc,
                                               input int unsigned     wait_w);
    longint unsigned prod;
    longint unsigned lim;
    prod = cnt * svc;
    lim  = (64'd1 << wait_w) - 64'd1;
    return (prod > lim) ? lim : prod;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer, consecutive-sample debounce filter and rising-edge pulse for one sensor.
module sensor_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [DW-1:0] r_stab;
  logic          r_level;
  logic          r_level_q;

  // r_stab counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= 2'b00;
      r_stab    <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_level_q <= r_level;
      if (r_sync[1] == r_level) begin
        r_stab <= '0;
      end else if (r_stab == LAST) begin
        r_stab  <= '0;
        r_level <= r_sync[1];
      end else begin
        r_stab <= r_stab + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_q;

endmodule

// File: rtl/queue_count_ctrl.sv
// Queue occupancy controller: debounced entry/exit sensors drive an up/down counter with
// overflow/underflow rejection, one-deep pending capture and a saturating wait estimate.
//
// state  | meaning
// IDLE   | waiting for an arrival/departure event or pending flag
// INC    | up pulse high, count increments at end of cycle
// DEC    | down pulse high, count decrements at end of cycle
// REJECT | overflow or underflow pulse high, count unchanged
module queue_count_ctrl
  import queue_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int MAX_COUNT  = DEF_MAX_COUNT,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SVC_MIN    = DEF_SVC_MIN,
  parameter int WAIT_W     = DEF_WAIT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Fsen,
  input  logic              Bsen,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              up,
  output logic              down,
  output logic              overflow,
  output logic              underflow,
  output logic [WAIT_W-1:0] wait_min
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic w_arr_lvl, w_dep_lvl;
  logic w_arr_ev, w_dep_ev;
  logic w_arr, w_dep;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic              r_up, r_down, r_ovf, r_unf;
  logic              r_pend_arr, r_pend_dep;
  logic [WAIT_W-1:0] r_wait;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_front (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_raw   (Fsen),
    .o_level (w_arr_lvl),
    .o_rise  (w_arr_ev)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_back (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_raw   (Bsen),
    .o_level (w_dep_lvl),
    .o_rise  (w_dep_ev)
  );

  assign w_arr = w_arr_ev | r_pend_arr;
  assign w_dep = w_dep_ev | r_pend_dep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_pend_arr <= 1'b0;
      r_pend_dep <= 1'b0;
    end else begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      case (r_state)
        IDLE: begin
          // Pending flags are consumed here whether serviced, rejected or cancelled.
          r_pend_arr <= 1'b0;
          r_pend_dep <= 1'b0;
          if (w_arr && w_dep) begin
            r_state <= IDLE;
          end else if (w_arr) begin
            if (r_count < MAX_C) begin
              r_state <= INC;
              r_up    <= 1'b1;
            end else begin
              r_state <= REJECT;
              r_ovf   <= 1'b1;
            end
          end else if (w_dep) begin
            if (r_count != '0) begin
              r_state <= DEC;
              r_down  <= 1'b1;
            end else begin
              r_state <= REJECT;
              r_unf   <= 1'b1;
            end
          end
        end
        INC: begin
          r_count <= r_count + 1'b1;
          r_state <= IDLE;
        end
        DEC: begin
          r_count <= r_count - 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      if (r_state != IDLE) begin
        if (w_arr_ev) r_pend_arr <= 1'b1;
        if (w_dep_ev) r_pend_dep <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else begin
      r_wait <= WAIT_W'(sat_wait(longint'(r_count), longint'(SVC_MIN), WAIT_W));
    end
  end

  assign count     = r_count;
  assign full      = (r_count == MAX_C);
  assign empty     = (r_count == '0);
  assign up        = r_up;
  assign down      = r_down;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign wait_min  = r_wait;

endmodule

// File: tb/tb_queue_count_ctrl.sv
// Directed bench for queue_count_ctrl with DEB_CYCLES=4, MAX_COUNT=3, SVC_MIN=3.
module tb_queue_count_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       Fsen, Bsen;
  logic [3:0] count;
  logic       full, empty, up, down, overflow, underflow;
  logic [7:0] wait_min;

  int errors = 0;
  int checks = 0;
  int n_up, n_dn, n_ov, n_un, cyc, first_up, first_dn;

  queue_count_ctrl #(
    .DEB_CYCLES(4), .MAX_COUNT(3), .CNT_W(4), .SVC_MIN(3), .WAIT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .Fsen(Fsen), .Bsen(Bsen),
    .count(count), .full(full), .empty(empty),
    .up(up), .down(down), .overflow(overflow), .underflow(underflow),
    .wait_min(wait_min)
  );

  always #5 clk = ~clk;

  task automatic clear_counts();
    n_up = 0; n_dn = 0; n_ov = 0; n_un = 0;
    cyc = 0; first_up = -1; first_dn = -1;
  endtask

  // Drive sensors for n cycles, tallying output pulse cycles sampled on the falling edge.
  task automatic run(input logic f, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      Fsen = f; Bsen = b;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (up)        begin n_up++; if (first_up < 0) first_up = cyc; end
      if (down)      begin n_dn++; if (first_dn < 0) first_dn = cyc; end
      if (overflow)  n_ov++;
      if (underflow) n_un++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Fsen = 1'b0; Bsen = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if ({up, down, overflow, underflow} !== 4'b0000)
      begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {up, down, overflow, underflow}); end
    checks++; if (wait_min !== 8'd0) begin errors++; $display("FAIL reset_wait got=%0d exp=0", wait_min); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      clear_counts();
      run(1'b1, 1'b0, 10);
      run(1'b0, 1'b0, 12);
      checks++; if (n_up != 1) begin errors++; $display("FAIL fill_up_pulses step=%0d got=%0d exp=1", i, n_up); end
      checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count step=%0d got=%0d exp=%0d", i, count, i + 1); end
      checks++; if (wait_min !== 8'(3 * (i + 1))) begin errors++; $display("FAIL fill_wait step=%0d got=%0d exp=%0d", i, wait_min, 3 * (i + 1)); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (wait_min !== 8'd9) begin errors++; $display("FAIL fill_wait_final got=%0d exp=9", wait_min); end
  endtask

  task automatic test_overflow();
    clear_counts();
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 12);
    checks++; if (n_ov != 1) begin errors++; $display("FAIL ovf_pulses got=%0d exp=1", n_ov); end
    checks++; if (n_up != 0) begin errors++; $display("FAIL ovf_up got=%0d exp=0", n_up); end
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL ovf_count got=%0d exp=3", count); end
  endtask

  task automatic test_drain();
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      run(1'b0, 1'b1, 10);
      run(1'b0, 1'b0, 12);
    end
    checks++; if (n_dn != 3) begin errors++; $display("FAIL drain_down got=%0d exp=3", n_dn); end
    checks++; if (n_un != 1) begin errors++; $display("FAIL drain_underflow got=%0d exp=1", n_un); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (wait_min !== 8'd0) begin errors++; $display("FAIL drain_wait got=%0d exp=0", wait_min); end
  endtask

  task automatic test_glitch();
    clear_counts();
    run(1'b1, 1'b0, 2);
    run(1'b0, 1'b0, 15);
    checks++; if (n_up != 0) begin errors++; $display("FAIL glitch_up got=%0d exp=0", n_up); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL glitch_count got=%0d exp=0", count); end
  endtask

  task automatic test_simultaneous();
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 12);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL simul_setup_count got=%0d exp=1", count); end
    clear_counts();
    run(1'b1, 1'b1, 10);
    run(1'b0, 1'b0, 12);
    checks++; if (n_up != 0 || n_dn != 0) begin errors++; $display("FAIL simul_updown got=%0d/%0d exp=0/0", n_up, n_dn); end
    checks++; if (n_ov != 0 || n_un != 0) begin errors++; $display("FAIL simul_ovf_unf got=%0d/%0d exp=0/0", n_ov, n_un); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL simul_count got=%0d exp=1", count); end
  endtask

  // Back sensor rises one cycle after front, so its event lands while the FSM is in INC.
  task automatic test_back_to_back();
    clear_counts();
    run(1'b1, 1'b0, 1);
    run(1'b1, 1'b1, 10);
    run(1'b0, 1'b1, 1);
    run(1'b0, 1'b0, 14);
    checks++; if (n_up != 1) begin errors++; $display("FAIL b2b_up got=%0d exp=1", n_up); end
    checks++; if (n_dn != 1) begin errors++; $display("FAIL b2b_down got=%0d exp=1", n_dn); end
    checks++; if (first_dn - first_up != 2) begin errors++; $display("FAIL b2b_gap got=%0d exp=2", first_dn - first_up); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL b2b_count got=%0d exp=1", count); end
  endtask

  task automatic test_reset_mid_inc();
    bit seen;
    run(1'b1, 1'b0, 10);
    run(1'b0, 1'b0, 12);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL rstinc_setup_count got=%0d exp=2", count); end
    seen = 1'b0;
    Fsen = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (up) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstinc_wait_up got=timeout exp=up within 40 cycles");
    end else begin
      rst = 1'b1; Fsen = 1'b0;
      #1;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstinc_count_in_rst got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstinc_empty_in_rst got=%b exp=1", empty); end
      checks++; if (up !== 1'b0) begin errors++; $display("FAIL rstinc_up_in_rst got=%b exp=0", up); end
      @(negedge clk);
      rst = 1'b0;
      clear_counts();
      run(1'b0, 1'b0, 20);
      checks++; if (n_up != 0) begin errors++; $display("FAIL rstinc_up_after got=%0d exp=0", n_up); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstinc_count_after got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstinc_empty_after got=%b exp=1", empty); end
    end
  endtask

  initial begin
    rst = 1'b1; Fsen = 1'b0; Bsen = 1'b0;
    clear_counts();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_inc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
